// File: rtl/excess3_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// excess3_scan_ctrl_if
// Bundle of the load handshake and display-side outputs of excess3_scan_ctrl.
//   load_valid  frame offered on load_data            (source -> controller)
//   load_ready  controller can accept a frame         (controller -> source)
//   load_data   NDIG packed excess-3 digits, digit k in [4k+3:4k]
//   dec_in      code for the shared decoder input, 0 = blank
//   digit_sel   one-hot digit position select, 0 when not scanning
//   busy        controller is working on a frame
//   err         one-cycle pulse: captured frame held an invalid code
//   done        one-cycle pulse at end of frame
// Modports: master = digit source / observer side, slave = controller side.
// ---------------------------------------------------------------------------
interface excess3_scan_ctrl_if #(
  parameter int NDIG = 4
);
  logic              load_valid;
  logic              load_ready;
  logic [4*NDIG-1:0] load_data;
  logic [3:0]        dec_in;
  logic [NDIG-1:0]   digit_sel;
  logic              busy;
  logic              err;
  logic              done;

  modport master (
    output load_valid, load_data,
    input  load_ready, dec_in, digit_sel, busy, err, done
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, dec_in, digit_sel, busy, err, done
  );
endinterface

// File: rtl/excess3_scan_ctrl.sv
// ---------------------------------------------------------------------------
// excess3_scan_ctrl
// Captures a frame of NDIG excess-3 digits, blanks invalid codes, then scans
// the digits one at a time onto the shared decoder input, holding each for
// DWELL cycles with a matching one-hot position select.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (returns to IDLE, clears buffer)
//   bus   excess3_scan_ctrl_if.slave: load_valid/load_ready/load_data in,
//         dec_in/digit_sel/busy/err/done out (all registered except
//         load_ready, which decodes the current state)
//
// Parameters: NDIG (1..8) digits per frame, DWELL (>=1) cycles per digit.
//
// Build option: define SCAN_REPEAT_EN for continuous refresh. The frame is
// rescanned without a gap, done pulses on each frame's last SCAN cycle and a
// new frame may be accepted during that cycle. Undefined: single-shot, with
// a one-cycle DONE state before returning to IDLE.
// ---------------------------------------------------------------------------
module excess3_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  excess3_scan_ctrl_if.slave  bus
);

  localparam int IDX_W   = (NDIG  > 1) ? $clog2(NDIG)  : 1;
  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NDIG - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [NDIG-1:0]    SEL_ONE    = NDIG'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [3:0]           buf_q [NDIG];
  logic [3:0]           buf_d [NDIG];
  logic [3:0]           dec_in_q, dec_in_d;
  logic [NDIG-1:0]      digit_sel_q, digit_sel_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 load_ready;

  logic [3:0]           load_digit  [NDIG];
  logic [3:0]           clean_digit [NDIG];
  logic [NDIG-1:0]      digit_bad;
  logic                 scan_last;

  // Per-digit unpacking of the load bus and validity check of the buffer.
  // Legal excess-3 codes are 3..12; anything else is blanked to 0.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      assign load_digit[gi]  = bus.load_data[4*gi +: 4];
      assign digit_bad[gi]   = (buf_q[gi] < 4'd3) || (buf_q[gi] > 4'd12);
      assign clean_digit[gi] = digit_bad[gi] ? 4'd0 : buf_q[gi];
    end
  endgenerate

  assign scan_last = (idx_q == IDX_LAST) && (dwell_q == DWELL_LAST);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dwell_d     = dwell_q;
    for (int k = 0; k < NDIG; k++) buf_d[k] = buf_q[k];
    load_ready  = 1'b0;
    err_d       = 1'b0;
    dec_in_d    = 4'd0;
    digit_sel_d = '0;
    done_d      = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        load_ready = 1'b1;
        if (bus.load_valid) begin
          for (int k = 0; k < NDIG; k++) buf_d[k] = load_digit[k];
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        for (int k = 0; k < NDIG; k++) buf_d[k] = clean_digit[k];
        err_d   = |digit_bad;
        idx_d   = '0;
        dwell_d = '0;
        state_d = S_SCAN;
      end

      S_SCAN: begin
        if (scan_last) begin
`ifdef SCAN_REPEAT_EN
          // Frame boundary: either take a new frame or rescan the buffer.
          load_ready = 1'b1;
          if (bus.load_valid) begin
            for (int k = 0; k < NDIG; k++) buf_d[k] = load_digit[k];
            state_d = S_CHECK;
          end else begin
            idx_d   = '0;
            dwell_d = '0;
          end
`else
          state_d = S_DONE;
`endif
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          idx_d   = idx_q + 1'b1;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state: the
    // value seen during a cycle reflects the state occupied in that cycle.
    busy_d = (state_d != S_IDLE);
    if (state_d == S_SCAN) begin
      dec_in_d    = buf_d[idx_d];
      digit_sel_d = SEL_ONE << idx_d;
    end
`ifdef SCAN_REPEAT_EN
    done_d = (state_d == S_SCAN) && (idx_d == IDX_LAST) && (dwell_d == DWELL_LAST);
`else
    done_d = (state_d == S_DONE);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      dwell_q     <= '0;
      for (int k = 0; k < NDIG; k++) buf_q[k] <= 4'd0;
      dec_in_q    <= 4'd0;
      digit_sel_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dwell_q     <= dwell_d;
      for (int k = 0; k < NDIG; k++) buf_q[k] <= buf_d[k];
      dec_in_q    <= dec_in_d;
      digit_sel_q <= digit_sel_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.dec_in     = dec_in_q;
  assign bus.digit_sel  = digit_sel_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_excess3_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_excess3_scan_ctrl
// Directed bench for excess3_scan_ctrl (NDIG=4, DWELL=2). Expected per-cycle
// outputs are pushed to a queue when a frame is offered and popped on every
// falling edge. Covers reset, valid frames, invalid-code blanking, busy
// rejection with back-to-back frames, asynchronous mid-scan reset, and (when
// SCAN_REPEAT_EN is defined) continuous refresh with a frame swap.
// ---------------------------------------------------------------------------
module tb_excess3_scan_ctrl;
  localparam int NDIG  = 4;
  localparam int DWELL = 2;
  localparam int NSCAN = NDIG * DWELL;
  localparam int LW    = 4 * NDIG;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  excess3_scan_ctrl_if #(.NDIG(NDIG)) bus ();

  excess3_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0]      dec;
    logic [NDIG-1:0] sel;
    logic            busy;
    logic            err;
    logic            done;
    logic            ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] clean(input logic [3:0] d);
    return ((d < 4'd3) || (d > 4'd12)) ? 4'd0 : d;
  endfunction

  task automatic push_check();
    exp_t e;
    e = '{dec: 4'd0, sel: '0, busy: 1'b1, err: 1'b0, done: 1'b0, ready: 1'b0};
    exp_q.push_back(e);
  endtask

  // One pass over the frame: NSCAN cycles of digit/position pairs.
  task automatic push_scan(input logic [LW-1:0] data, input bit rep, input bit first);
    exp_t       e;
    logic       bad;
    logic [3:0] dg;
    int         ix;
    bad = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      dg = data[4*k +: 4];
      if (clean(dg) == 4'd0) bad = 1'b1;
    end
    for (int i = 0; i < NSCAN; i++) begin
      ix      = i / DWELL;
      dg      = data[4*ix +: 4];
      e.dec   = clean(dg);
      e.sel   = NDIG'(1) << ix;
      e.busy  = 1'b1;
      e.err   = first && (i == 0) && bad;
      e.done  = rep && (i == NSCAN - 1);
      e.ready = rep && (i == NSCAN - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_tail();
    exp_t e;
    e = '{dec: 4'd0, sel: '0, busy: 1'b1, err: 1'b0, done: 1'b1, ready: 1'b0};
    exp_q.push_back(e);
    e = '{dec: 4'd0, sel: '0, busy: 1'b0, err: 1'b0, done: 1'b0, ready: 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic check_next(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard underflow observed=none expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".dec_in"},    32'(bus.dec_in),     32'(e.dec));
      chk({tag, ".digit_sel"}, 32'(bus.digit_sel),  32'(e.sel));
      chk({tag, ".busy"},      32'(bus.busy),       32'(e.busy));
      chk({tag, ".err"},       32'(bus.err),        32'(e.err));
      chk({tag, ".done"},      32'(bus.done),       32'(e.done));
      chk({tag, ".load_ready"},32'(bus.load_ready), 32'(e.ready));
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".dec_in"},     32'(bus.dec_in),     32'd0);
    chk({tag, ".digit_sel"},  32'(bus.digit_sel),  32'd0);
    chk({tag, ".busy"},       32'(bus.busy),       32'd0);
    chk({tag, ".err"},        32'(bus.err),        32'd0);
    chk({tag, ".done"},       32'(bus.done),       32'd0);
    chk({tag, ".load_ready"}, 32'(bus.load_ready), 32'd1);
  endtask

  // Offer a frame at the current falling edge and check the whole
  // single-shot sequence through the first IDLE cycle afterwards. With
  // hold set, load_valid stays high and load_data keeps changing.
  task automatic run_frame(input string tag, input logic [LW-1:0] data, input bit hold);
    chk({tag, ".ready_at_offer"}, 32'(bus.load_ready), 32'd1);
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    push_check();
    push_scan(data, 1'b0, 1'b1);
    push_tail();
    for (int n = 0; n < NSCAN + 3; n++) begin
      @(negedge clk);
      check_next(tag);
      if (!hold) bus.load_valid = 1'b0;
      else if (n < NSCAN + 2) bus.load_data = LW'($urandom);
    end
    $display("frame %s data=%h checks=%0d failures=%0d", tag, data, checks, failures);
  endtask

  initial begin
    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;

    // Reset held: outputs quiet, ready asserted.
    @(negedge clk);
    @(negedge clk);
    check_quiet("reset_held");
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check_quiet("idle_hold");
    end
    $display("reset/idle checks=%0d failures=%0d", checks, failures);

`ifndef SCAN_REPEAT_EN
    run_frame("f_c853", 16'hC853, 1'b0);
    run_frame("f_0ae7", 16'h0AE7, 1'b0);
    run_frame("f_hold", 16'h4567, 1'b1);
    run_frame("f_b2b",  16'h9BC3, 1'b0);

    // Asynchronous reset in the middle of digit 2.
    bus.load_valid = 1'b1;
    bus.load_data  = 16'hC853;
    @(negedge clk);
    bus.load_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst.pre_dec_in",    32'(bus.dec_in),    32'd8);
    chk("midrst.pre_digit_sel", 32'(bus.digit_sel), 32'b0100);
    #2 rst = 1'b1;
    #1 check_quiet("midrst.async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_quiet("midrst.released");
    run_frame("f_after_rst", 16'h5A63, 1'b0);
`else
    // Continuous refresh: three passes of one frame, then swap at a boundary.
    bus.load_valid = 1'b1;
    bus.load_data  = 16'hC853;
    push_check();
    push_scan(16'hC853, 1'b1, 1'b1);
    push_scan(16'hC853, 1'b1, 1'b0);
    push_scan(16'hC853, 1'b1, 1'b0);
    for (int n = 0; n < 1 + 3*NSCAN; n++) begin
      @(negedge clk);
      check_next("rep_c853");
      bus.load_valid = 1'b0;
    end
    $display("frame rep_c853 checks=%0d failures=%0d", checks, failures);
    bus.load_valid = 1'b1;
    bus.load_data  = 16'h3333;
    push_check();
    push_scan(16'h3333, 1'b1, 1'b1);
    for (int n = 0; n < 1 + NSCAN; n++) begin
      @(negedge clk);
      check_next("rep_3333");
      bus.load_valid = 1'b0;
    end
    $display("frame rep_3333 checks=%0d failures=%0d", checks, failures);
`endif

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
